m_beep_gen: RTL and testbench

//   Buzzer burst generator, directly downstream of the UART command frame decoder.
//   On a one-cycle command strobe it latches period, high-time and pulse count.
//   It then drives o_beep with o_num PWM periods, each o_high cycles high and the rest low.

---
 rtl/m_beep_gen_if.sv | 27 ++
 rtl/m_beep_gen.sv | 108 ++++++++++
 tb/tb_m_beep_gen.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/m_beep_gen_if.sv
// Command/status bundle between the UART frame decoder and the buzzer
// burst generator.
// Handshake: i_beep_en is a one-cycle strobe, with no ready. The command
// fields are sampled only on the edge where i_beep_en=1 is accepted.
// o_done and o_cmd_err are one-cycle status pulses. o_state mirrors the FSM
// state so it can be observed while debugging.
interface m_beep_gen_if;
  logic        i_beep_en;
  logic [31:0] i_beep_period;
  logic [31:0] i_beep_high;
  logic [15:0] i_beep_num;
  logic        o_beep;
  logic        o_busy;
  logic        o_done;
  logic        o_cmd_err;
  logic [1:0]  o_state;

  modport master (
    output i_beep_en, i_beep_period, i_beep_high, i_beep_num,
    input  o_beep, o_busy, o_done, o_cmd_err, o_state
  );

  modport slave (
    input  i_beep_en, i_beep_period, i_beep_high, i_beep_num,
    output o_beep, o_busy, o_done, o_cmd_err, o_state
  );
endinterface

// File: rtl/m_beep_gen.sv
// Buzzer burst generator. A command strobe latches period, high time and
// count. The block then plays o_num PWM periods on a registered o_beep.
// Optional macro BEEP_RETRIGGER_EN: when defined, a strobe during a running
// burst aborts that burst and restarts it with the new command.
// When the macro is undefined, a strobe during a running burst is ignored.
module m_beep_gen (
  input  logic       i_clk,
  input  logic       i_rst_n,
  m_beep_gen_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

`ifdef BEEP_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic [1:0]  r_state;
  logic [31:0] r_period_l;
  logic [31:0] r_high_l;
  logic [15:0] r_num_l;
  logic [31:0] r_cnt;
  logic [15:0] r_pcnt;
  logic        r_beep;
  logic        r_done;
  logic        r_cmd_err;

  logic        accept;
  logic        cmd_bad;
  logic [31:0] high_clamped;

  // Command decode: is a strobe taken this edge, is it legal, and what is the
  // high time after clamping it to the period.
  always_comb begin
    accept       = bus.i_beep_en && ((r_state != ST_RUN) || RETRIG);
    cmd_bad      = (bus.i_beep_period == '0) || (bus.i_beep_num == '0);
    high_clamped = (bus.i_beep_high >= bus.i_beep_period) ? bus.i_beep_period
                                                          : bus.i_beep_high;
  end

  // Burst FSM, PWM counters and registered outputs.
  // If a command is rejected in the DONE cycle, the completion pulse takes
  // priority over the error pulse, so the two are never high together.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_period_l <= '0;
      r_high_l   <= '0;
      r_num_l    <= '0;
      r_cnt      <= '0;
      r_pcnt     <= '0;
      r_beep     <= 1'b0;
      r_done     <= 1'b0;
      r_cmd_err  <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_cmd_err <= 1'b0;
      if (accept) begin
        r_beep <= 1'b0;
        if (r_state == ST_DONE) r_done <= 1'b1;
        if (cmd_bad) begin
          r_state <= ST_IDLE;
          if (r_state != ST_DONE) r_cmd_err <= 1'b1;
        end else begin
          r_period_l <= bus.i_beep_period;
          r_high_l   <= high_clamped;
          r_num_l    <= bus.i_beep_num;
          r_cnt      <= '0;
          r_pcnt     <= '0;
          r_state    <= ST_RUN;
        end
      end else begin
        case (r_state)
          ST_RUN: begin
            r_beep <= (r_cnt < r_high_l);
            if (r_cnt == r_period_l - 32'd1) begin
              r_cnt <= '0;
              if (r_pcnt == r_num_l - 16'd1) r_state <= ST_DONE;
              else                           r_pcnt  <= r_pcnt + 16'd1;
            end else begin
              r_cnt <= r_cnt + 32'd1;
            end
          end
          ST_DONE: begin
            r_done  <= 1'b1;
            r_beep  <= 1'b0;
            r_state <= ST_IDLE;
          end
          default: begin
            r_beep  <= 1'b0;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.o_beep    = r_beep;
  assign bus.o_busy    = (r_state == ST_RUN);
  assign bus.o_done    = r_done;
  assign bus.o_cmd_err = r_cmd_err;
  assign bus.o_state   = r_state;

endmodule

// File: tb/tb_m_beep_gen.sv
// Bench for m_beep_gen. It uses a table of commands, with expected output
// words pushed to exp_q and compared once per cycle on the falling edge.
// Expected word bit order: {o_beep, o_busy, o_done, o_cmd_err}.
module tb_m_beep_gen;

  logic clk;
  logic rst_n;
  m_beep_gen_if bif ();

  m_beep_gen dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bif)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q[$];

  typedef struct {
    int p;
    int h;
    int n;
    bit rej;
  } vec_t;

  vec_t vecs[9];

  // Expected word k edges after the accept edge E0 of a legal command.
  function automatic logic [3:0] exp_word(int p, int h, int n, int k);
    int hc;
    int pn;
    hc = (h > p) ? p : h;
    pn = p * n;
    if (k == 0) return 4'b0100;
    if (k <= pn) return {(((k - 1) % p) < hc) ? 1'b1 : 1'b0, (k < pn) ? 1'b1 : 1'b0, 2'b00};
    if (k == pn + 1) return 4'b0010;
    return 4'b0000;
  endfunction

  task automatic push_burst(int p, int h, int n, int k_from, int k_to);
    for (int k = k_from; k <= k_to; k++) exp_q.push_back(exp_word(p, h, n, k));
  endtask

  // driver: present a command; it is sampled at the next rising edge
  task automatic strobe(int p, int h, int n);
    bif.i_beep_en     = 1'b1;
    bif.i_beep_period = 32'(p);
    bif.i_beep_high   = 32'(h);
    bif.i_beep_num    = 16'(n);
  endtask

  task automatic check_pop(string name);
    logic [3:0] got;
    logic [3:0] exp;
    got = {bif.o_beep, bif.o_busy, bif.o_done, bif.o_cmd_err};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got %b but expected queue is empty", name, got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL %s t=%0t: {beep,busy,done,err} got %b want %b", name, $time, got, exp);
      end
    end
  endtask

  // Advance cnt cycles, dropping the strobe and scrambling the ignored fields.
  task automatic run_cycles(int cnt, string name);
    for (int i = 0; i < cnt; i++) begin
      @(posedge clk);
      @(negedge clk);
      bif.i_beep_en     = 1'b0;
      bif.i_beep_period = $urandom_range(0, 50);
      bif.i_beep_high   = $urandom_range(0, 50);
      bif.i_beep_num    = 16'($urandom_range(0, 5));
      check_pop(name);
    end
  endtask

  initial begin
    vecs[0] = '{10, 3, 4, 1'b0};
    vecs[1] = '{5, 9, 3, 1'b0};
    vecs[2] = '{5, 0, 2, 1'b0};
    vecs[3] = '{0, 3, 2, 1'b1};
    vecs[4] = '{6, 2, 0, 1'b1};
    vecs[5] = '{1, 1, 3, 1'b0};
    vecs[6] = '{3, 1, 2, 1'b0};
    vecs[7] = '{7, 7, 1, 1'b0};
    vecs[8] = '{4, 5, 2, 1'b0};

    rst_n = 1'b0;
    bif.i_beep_en = 1'b0;
    bif.i_beep_period = '0;
    bif.i_beep_high = '0;
    bif.i_beep_num = '0;

    // reset state
    @(negedge clk);
    exp_q.push_back(4'b0000);
    exp_q.push_back(4'b0000);
    run_cycles(2, "reset");
    checks++;
    if (bif.o_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d want 0", bif.o_state);
    end
    rst_n = 1'b1;
    exp_q.push_back(4'b0000);
    run_cycles(1, "idle");

    // table-driven commands
    for (int v = 0; v < 9; v++) begin
      strobe(vecs[v].p, vecs[v].h, vecs[v].n);
      if (vecs[v].rej) begin
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0000);
        run_cycles(2, $sformatf("vec%0d_reject", v));
      end else begin
        push_burst(vecs[v].p, vecs[v].h, vecs[v].n, 0, vecs[v].p * vecs[v].n + 2);
        run_cycles(vecs[v].p * vecs[v].n + 3, $sformatf("vec%0d", v));
      end
    end

    // reset at cycle 15 of a 10/3/4 burst aborts it without o_done
    strobe(10, 3, 4);
    push_burst(10, 3, 4, 0, 14);
    run_cycles(15, "rst_mid_pre");
    rst_n = 1'b0;
    exp_q.push_back(4'b0000);
    run_cycles(1, "rst_mid");
    rst_n = 1'b1;
    repeat (3) exp_q.push_back(4'b0000);
    run_cycles(3, "rst_mid_post");

    // new command in the DONE cycle chains a second burst
    strobe(2, 1, 2);
    push_burst(2, 1, 2, 0, 4);
    run_cycles(5, "chain_a");
    strobe(4, 2, 1);
    exp_q.push_back(4'b0110);
    push_burst(4, 2, 1, 1, 6);
    run_cycles(7, "chain_b");

    // strobe at cycle 12 of a 10/3/4 burst
    strobe(10, 3, 4);
    push_burst(10, 3, 4, 0, 11);
    run_cycles(12, "retrig_pre");
    strobe(4, 2, 1);
`ifdef BEEP_RETRIGGER_EN
    exp_q.push_back(4'b0100);
    push_burst(4, 2, 1, 1, 6);
    run_cycles(7, "retrig_new");
`else
    push_burst(10, 3, 4, 12, 42);
    run_cycles(31, "retrig_ignored");
`endif

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expected words never compared", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
